mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store unit between the CPU execute stage and the byte-addressed dual-port data RAM. It accepts one byte, halfword or word access per request over a valid/ready handshake. Loads are aligned, lane-extracted and zero- or sign-extended. Sub-word stores are done as read-modify-write, because the RAM write port always writes a full 32-bit little-endian word.

Parameters:
MEM_CAPACITY  4096  RAM size in bytes; any access with addr >= MEM_CAPACITY is an error
ADDR_W  32  request and memory address width

Ports:
m_clock  in  1  clock; all state changes on rising edge
p_reset  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: sign-extend
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, illegal size or out-of-range access
mem_addr_r  out  ADDR_W  RAM read address, word-aligned
mem_rdata  in  32  RAM read data, combinational from mem_addr_r
mem_addr_w  out  ADDR_W  RAM write address, word-aligned
mem_wdata  out  32  RAM write word
mem_we  out  1  RAM write enable

Behaviour:
- Reset (p_reset=0 at an edge): state IDLE; req_ready=1 and all other outputs 0 from the next cycle.
- Reset mid-operation aborts the access. No mem_we is issued after the reset edge. A pending response is dropped.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/size/signed/wdata and evaluate errors:
  - err when size==11;
  - err when size==01 and addr[0]!=0;
  - err when size==10 and addr[1:0]!=0;
  - err when addr > MEM_CAPACITY-4.
  - err -> RESP; otherwise -> READ.
- req_ready=0 in all states other than IDLE. There is no request overlap.
- READ: mem_addr_r = {addr[ADDR_W-1:2],2'b00}. Register mem_rdata into rbuf at the end of the cycle. Load -> RESP; store -> WRITE.
- WRITE: one cycle with mem_we=1, mem_addr_w = aligned address, mem_wdata = rbuf with the selected lanes replaced by wdata.
  - Byte lane = addr[1:0]; half lanes = addr[1]*2..+1; word replaces all four lanes.
  - Little-endian: lane 0 = bits 7:0.
  - Next state RESP.
- mem_we is 0 in every other state. mem_addr_r and mem_addr_w hold the aligned address while busy and are 0 in IDLE.
- RESP: resp_valid=1. resp_rdata/resp_err are stable until resp_valid&&resp_ready; then -> IDLE.
- Load result: the lane field of rbuf is shifted to bit 0, then zero- or sign-extended (sign bit 7 or 15) per the latched signed flag. Word loads ignore signed.
- Stores return resp_rdata=0.
- Error responses: resp_err=1, resp_rdata=0, RAM never read or written.
- Latency (accept edge = T, resp_ready=1):
  - load: resp_valid during cycle T+2;
  - store: mem_we during T+2, resp_valid during T+3;
  - error: resp_valid during T+1.
- Back-to-back: the next request can be accepted in the cycle after the response handshake.

Decomposition:
- Package mau_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state enum (IDLE, READ, WRITE, RESP);
  - function align_mask.
- Sub-module mau_lane_align (purely combinational) provides:
  - load extract/extend: rbuf, addr[1:0], size, signed -> rdata;
  - store merge: rbuf, wdata, addr[1:0], size -> merged word.
- The FSM and registers remain in mem_access_unit.

Test Plan:
All cases pre-load RAM word 0x100 = 0x88776655.
1. Signed byte load, addr 0x103 -> resp_valid at T+2, resp_rdata 0xFFFFFF88, resp_err 0; unsigned gives 0x00000088.
2. Unsigned half load, addr 0x102 -> 0x00008877; signed -> 0xFFFF8877; word load, addr 0x100 -> 0x88776655.
3. Store byte 0xAB to 0x101 -> single mem_we cycle at T+2 with mem_addr_w 0x100, mem_wdata 0x8877AB55. A following word load returns 0x8877AB55.
4. Error cases:
   - store half to 0x101 -> resp_err=1 at T+1, resp_rdata 0, mem_we never 1;
   - size 11 -> error;
   - word access at MEM_CAPACITY-2 -> error.
5. resp_ready held 0 for 3 cycles -> resp_valid and data stay stable, req_ready=0. A concurrent req_valid is not accepted and is served only after the handshake.
6. p_reset=0 during READ of a word store -> mem_we never asserted, RAM word unchanged. Next cycle req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the load/store unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: align_mask = 2'b00;
      SZ_HALF: align_mask = 2'b01;
      default: align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [31:0] wshift;
  logic [3:0]  bmask;

  always_comb begin
    shifted = rbuf >> {lane, 3'b000};
    case (size)
      SZ_BYTE: rdata = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: rdata = rbuf;
    endcase
  end

  always_comb begin
    wshift = wdata << {lane, 3'b000};
    case (size)
      SZ_BYTE: bmask = 4'b0001 << lane;
      SZ_HALF: bmask = 4'b0011 << {lane[1], 1'b0};
      default: bmask = 4'b1111;
    endcase
    merged = rbuf;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bmask[i]) merged[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one byte/half/word access per request, sub-word stores by read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_CAPACITY = 4096,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [31:0]       mem_wdata,
  output logic              mem_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_CAPACITY - 4);

  state_t            state, state_n;
  logic              we_q, sgn_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q, rbuf;
  logic              req_err;
  logic [ADDR_W-1:0] aligned;
  logic [31:0]       load_data, merged;

  assign aligned = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_err = (req_size == SZ_ILL)
           || ((req_addr[1:0] & align_mask(req_size)) != 2'b00)
           || (req_addr > LAST_ADDR);
  end

  mau_lane_align u_align (
    .rbuf   (rbuf),
    .wdata  (wdata_q),
    .lane   (addr_q[1:0]),
    .size   (size_q),
    .sgn    (sgn_q),
    .rdata  (load_data),
    .merged (merged)
  );

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        err_q   <= req_err;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        rbuf    <= '0;
      end
      if (state == READ) rbuf <= mem_rdata;
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr_r = '0;
    mem_addr_w = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = req_err ? RESP : READ;
      end
      READ: begin
        mem_addr_r = aligned;
        mem_addr_w = aligned;
        state_n    = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr_r = aligned;
        mem_addr_w = aligned;
        mem_wdata  = merged;
        mem_we     = 1'b1;
        state_n    = RESP;
      end
      RESP: begin
        mem_addr_r = aligned;
        mem_addr_w = aligned;
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : load_data;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, hand-written corner sequences, random traffic vs byte-array model.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int unsigned CAP = 4096;

  logic        m_clock, p_reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr_r, mem_rdata, mem_addr_w, mem_wdata;
  logic        mem_we;

  logic [31:0] ram [0:1023];
  logic [7:0]  mb  [0:CAP-1];
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wword;
  } vec_t;

  mem_access_unit #(.MEM_CAPACITY(CAP), .ADDR_W(32)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr_r (mem_addr_r),
    .mem_rdata  (mem_rdata),
    .mem_addr_w (mem_addr_w),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  assign mem_rdata = (mem_addr_r < CAP) ? ram[mem_addr_r[11:2]] : 32'h0;

  always @(posedge m_clock) begin
    if (ld_en) ram[ld_idx] <= ld_data;
    else if (mem_we && mem_addr_w < CAP) ram[mem_addr_w[11:2]] <= mem_wdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input logic [31:0] wword);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn;
    v.wdata = wdata; v.rdata = rdata; v.err = err; v.wword = wword;
    return v;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  // Byte-array reference: predicts result and commits successful stores.
  task automatic model_predict(input vec_t vi, output vec_t vo);
    int unsigned n;
    longint val;
    vo = vi;
    vo.rdata = 32'h0;
    vo.wword = 32'h0;
    n = 1 << vi.size;
    vo.err = (vi.size == 2'b11) || (vi.addr % n != 0) || (vi.addr > CAP - 4);
    if (vo.err) return;
    if (vi.we) begin
      for (int unsigned i = 0; i < n; i++) mb[vi.addr + i] = 8'(vi.wdata >> (8 * i));
      vo.wword = model_word(vi.addr - vi.addr % 4);
    end else begin
      val = 0;
      for (int unsigned i = 0; i < n; i++) val += longint'(mb[vi.addr + i]) << (8 * i);
      if (vi.sgn && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
      vo.rdata = val[31:0];
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat = -1;
    int wecnt = 0;
    int wecyc = -1;
    int exp_lat;
    logic [31:0] waddr = '0;
    logic [31:0] wdat = '0;
    @(negedge m_clock);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_addr   = v.addr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_wdata  = v.wdata;
    @(posedge m_clock);
    for (int n = 1; n <= 12; n++) begin
      @(negedge m_clock);
      if (n == 1) req_valid = 1'b0;
      if (mem_we) begin
        wecnt++;
        wecyc = n;
        waddr = mem_addr_w;
        wdat  = mem_wdata;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    exp_lat = v.err ? 1 : (v.we ? 3 : 2);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, v.rdata);
    check({tag, " err"}, 32'(resp_err), 32'(v.err));
    check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
    check({tag, " mem_we count"}, 32'(wecnt), (v.we && !v.err) ? 32'd1 : 32'd0);
    if (v.we && !v.err) begin
      check({tag, " mem_we cycle"}, 32'(wecyc), 32'd2);
      check({tag, " mem_addr_w"}, waddr, {v.addr[31:2], 2'b00});
      check({tag, " mem_wdata"}, wdat, v.wword);
    end
  endtask

  vec_t tbl[$];
  vec_t rv, pv;
  int   we_seen;

  initial begin
    p_reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    ld_en = 1'b1; ld_idx = '0; ld_data = '0;

    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      @(negedge m_clock);
      w = (i == 64) ? 32'h88776655 : (i == 1023) ? 32'h11223344 : $urandom;
      ld_idx = 10'(i);
      ld_data = w;
      for (int b = 0; b < 4; b++) mb[4*i + b] = 8'(w >> (8 * b));
    end
    @(negedge m_clock);
    ld_en = 1'b0;

    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr_r", mem_addr_r, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    p_reset = 1'b1;

    tbl.push_back(mk(0, 32'h103, SZ_BYTE, 1, 0, 32'hFFFFFF88, 0, 0));
    tbl.push_back(mk(0, 32'h103, SZ_BYTE, 0, 0, 32'h00000088, 0, 0));
    tbl.push_back(mk(0, 32'h102, SZ_HALF, 0, 0, 32'h00008877, 0, 0));
    tbl.push_back(mk(0, 32'h102, SZ_HALF, 1, 0, 32'hFFFF8877, 0, 0));
    tbl.push_back(mk(0, 32'h100, SZ_WORD, 1, 0, 32'h88776655, 0, 0));
    tbl.push_back(mk(1, 32'h101, SZ_BYTE, 0, 32'h000000AB, 32'h0, 0, 32'h8877AB55));
    tbl.push_back(mk(0, 32'h100, SZ_WORD, 0, 0, 32'h8877AB55, 0, 0));
    tbl.push_back(mk(1, 32'h101, SZ_HALF, 0, 32'h00001234, 32'h0, 1, 0));
    tbl.push_back(mk(0, 32'h100, SZ_ILL,  0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, CAP - 2, SZ_WORD, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, CAP - 4, SZ_WORD, 0, 0, 32'h11223344, 0, 0));
    tbl.push_back(mk(0, CAP - 3, SZ_BYTE, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, CAP,     SZ_WORD, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 32'h100, SZ_BYTE, 1, 0, 32'h00000055, 0, 0));
    tbl.push_back(mk(1, 32'h102, SZ_HALF, 0, 32'hFFFFBEEF, 32'h0, 0, 32'hBEEFAB55));
    tbl.push_back(mk(0, 32'h103, SZ_BYTE, 1, 0, 32'hFFFFFFBE, 0, 0));
    tbl.push_back(mk(1, 32'h102, SZ_HALF, 0, 32'h00008877, 32'h0, 0, 32'h8877AB55));
    foreach (tbl[i]) begin
      model_predict(tbl[i], pv);
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Backpressure: first response held, concurrent request waits for the handshake.
    @(negedge m_clock);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = SZ_BYTE; req_signed = 1'b0;
    @(posedge m_clock);
    @(negedge m_clock);
    req_size = SZ_WORD;
    @(negedge m_clock);
    check("bp resp_valid", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge m_clock);
      check("bp hold resp_valid", 32'(resp_valid), 32'd1);
      check("bp hold rdata", resp_rdata, 32'h00000055);
      check("bp hold req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge m_clock);
    @(negedge m_clock);
    check("bp after hs resp_valid", 32'(resp_valid), 32'd0);
    check("bp after hs req_ready", 32'(req_ready), 32'd1);
    @(posedge m_clock);
    begin
      int lat2 = -1;
      for (int n = 1; n <= 12; n++) begin
        @(negedge m_clock);
        if (n == 1) req_valid = 1'b0;
        if (resp_valid) begin lat2 = n; break; end
      end
      check("bp second latency", 32'(lat2), 32'd2);
      check("bp second rdata", resp_rdata, 32'h8877AB55);
    end

    // Reset while a word store sits in READ: the write must never happen.
    @(negedge m_clock);
    we_seen = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_size = SZ_WORD; req_wdata = 32'hDEADBEEF;
    @(posedge m_clock);
    @(negedge m_clock);
    req_valid = 1'b0;
    p_reset = 1'b0;
    if (mem_we) we_seen++;
    @(posedge m_clock);
    @(negedge m_clock);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    if (mem_we) we_seen++;
    p_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge m_clock);
      if (mem_we) we_seen++;
    end
    check("rst mem_we count", 32'(we_seen), 32'd0);
    check("rst ram word", ram[64], 32'h8877AB55);
    run_vec(mk(0, 32'h100, SZ_WORD, 0, 0, 32'h8877AB55, 0, 0), "rst reload");

    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(15);
      rv.we    = 1'($urandom);
      rv.size  = (r == 0) ? SZ_ILL : 2'(r % 3);
      rv.sgn   = 1'($urandom);
      rv.wdata = $urandom;
      rv.addr  = ($urandom_range(7) == 0) ? (CAP - 16 + $urandom_range(23)) : (32'hF0 + $urandom_range(31));
      model_predict(rv, pv);
      run_vec(pv, $sformatf("rnd%0d", i));
    end

    @(negedge m_clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
